// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle MIPS core: sequences fetch/decode/execute/
// memory/writeback per opcode, drives datapath controls and counts retired instructions.
module multicycle_main_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             branch,
    output logic             branch_ne,
    output logic [1:0]       pc_src,
    output logic             iord,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             zero_ext,
    output logic [2:0]       alu_op,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        IMMEXEC  = 4'd9,
        IMMWB    = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_SLTI = 6'b001010;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_XOR   = 3'd4;
    localparam logic [2:0] ALU_SLT   = 3'd5;
    localparam logic [2:0] ALU_FUNCT = 3'd7;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       branch_ne;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       zero_ext;
        logic [2:0] alu_op;
    } ctrl_t;

    // Controls for the state being entered; opcode is stable from DECODE onward.
    function automatic ctrl_t decode(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c        = '0;
        c.alu_op = ALU_ADD;
        case (s)
            FETCH:    c.alu_src_b = 2'b01;
            DECODE:   c.alu_src_b = 2'b11;
            MEMADR:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            MEMREAD:  c.iord = 1'b1;
            MEMWB:    begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
            MEMWRITE: begin c.iord = 1'b1; c.mem_write = 1'b1; end
            EXECUTE:  begin c.alu_src_a = 1'b1; c.alu_op = ALU_FUNCT; end
            ALUWB:    begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
            BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_SUB;
                c.pc_src    = 2'b01;
                c.branch    = (op == OP_BEQ);
                c.branch_ne = (op == OP_BNE);
            end
            IMMEXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                case (op)
                    OP_ANDI: begin c.alu_op = ALU_AND; c.zero_ext = 1'b1; end
                    OP_ORI:  begin c.alu_op = ALU_OR;  c.zero_ext = 1'b1; end
                    OP_XORI: begin c.alu_op = ALU_XOR; c.zero_ext = 1'b1; end
                    OP_SLTI: c.alu_op = ALU_SLT;
                    default: c.alu_op = ALU_ADD;
                endcase
            end
            IMMWB:    c.reg_write = 1'b1;
            JUMP:     begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    state_t st, nxt;
    ctrl_t  ctrl;
    logic   retire;
    logic   fetch_go;

    always_comb begin
        nxt = st;
        case (st)
            FETCH:    if (mem_ready) nxt = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:   nxt = MEMADR;
                    OP_R:           nxt = EXECUTE;
                    OP_BEQ, OP_BNE: nxt = BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: nxt = IMMEXEC;
                    OP_J:           nxt = JUMP;
                    default:        nxt = FETCH;
                endcase
            end
            MEMADR:   nxt = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  if (mem_ready) nxt = MEMWB;
            MEMWRITE: if (mem_ready) nxt = FETCH;
            EXECUTE:  nxt = ALUWB;
            IMMEXEC:  nxt = IMMWB;
            MEMWB, ALUWB, IMMWB, BRANCH, JUMP: nxt = FETCH;
            default:  nxt = FETCH;
        endcase
    end

    always_comb begin
        retire = (nxt == FETCH) && (st inside {MEMWB, MEMWRITE, ALUWB, IMMWB, BRANCH, JUMP});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= FETCH;
            ctrl        <= decode(FETCH, '0);
            illegal_op  <= 1'b0;
            instr_count <= '0;
        end else begin
            st          <= nxt;
            ctrl        <= decode(nxt, opcode);
            illegal_op  <= (st == DECODE) && (nxt == FETCH);
            if (retire) instr_count <= instr_count + CNT_W'(1);
        end
    end

    // FETCH strobes follow mem_ready within the cycle, so they bypass the register.
    assign fetch_go   = (st == FETCH) && mem_ready && !rst;
    assign ir_write   = fetch_go;
    assign pc_write   = ctrl.pc_write | fetch_go;
    assign branch     = ctrl.branch;
    assign branch_ne  = ctrl.branch_ne;
    assign pc_src     = ctrl.pc_src;
    assign iord       = ctrl.iord;
    assign mem_write  = ctrl.mem_write;
    assign reg_write  = ctrl.reg_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign zero_ext   = ctrl.zero_ext;
    assign alu_op     = ctrl.alu_op;
    assign state      = st;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed scoreboard bench for multicycle_main_fsm; a narrow counter makes wrap-around reachable.
module tb_multicycle_main_fsm;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    opcode = '0;
    logic          mem_ready = 1'b0;
    logic          ir_write, pc_write, branch, branch_ne, iord, mem_write, reg_write;
    logic          reg_dst, mem_to_reg, alu_src_a, zero_ext, illegal_op;
    logic [1:0]    pc_src, alu_src_b;
    logic [2:0]    alu_op;
    logic [CW-1:0] instr_count;
    logic [3:0]    state;

    multicycle_main_fsm #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .ir_write(ir_write), .pc_write(pc_write), .branch(branch), .branch_ne(branch_ne),
        .pc_src(pc_src), .iord(iord), .mem_write(mem_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .zero_ext(zero_ext), .alu_op(alu_op),
        .illegal_op(illegal_op), .instr_count(instr_count), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ir_write, pc_write, branch, branch_ne;
        logic [1:0] pc_src;
        logic       iord, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b;
        logic       zero_ext;
        logic [2:0] alu_op;
        logic       illegal_op;
    } outs_t;

    typedef struct {
        string         tag;
        logic [3:0]    st;
        outs_t         outs;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   fails   = 0;
    int   ecnt    = 0;

    function automatic outs_t exp_ctrl(int st, logic [5:0] op, logic rdy, logic ill);
        outs_t o;
        o = '0;
        case (st)
            0:  begin o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
            1:  o.alu_src_b = 2'b11;
            2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            3:  o.iord = 1;
            4:  begin o.mem_to_reg = 1; o.reg_write = 1; end
            5:  begin o.iord = 1; o.mem_write = 1; end
            6:  begin o.alu_src_a = 1; o.alu_op = 3'd7; end
            7:  begin o.reg_dst = 1; o.reg_write = 1; end
            8:  begin
                o.alu_src_a = 1; o.alu_op = 3'd1; o.pc_src = 2'b01;
                o.branch = (op == 6'b000100); o.branch_ne = (op == 6'b000101);
            end
            9:  begin
                o.alu_src_a = 1; o.alu_src_b = 2'b10;
                case (op)
                    6'b001100: begin o.alu_op = 3'd2; o.zero_ext = 1; end
                    6'b001101: begin o.alu_op = 3'd3; o.zero_ext = 1; end
                    6'b001110: begin o.alu_op = 3'd4; o.zero_ext = 1; end
                    6'b001010: o.alu_op = 3'd5;
                    default:   o.alu_op = 3'd0;
                endcase
            end
            10: o.reg_write = 1;
            11: begin o.pc_src = 2'b10; o.pc_write = 1; end
            default: o = '0;
        endcase
        o.illegal_op = ill;
        return o;
    endfunction

    task automatic check();
        exp_t  e;
        outs_t obs;
        e   = sb.pop_front();
        obs = '{ir_write, pc_write, branch, branch_ne, pc_src, iord, mem_write, reg_write,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, zero_ext, alu_op, illegal_op};
        vectors++;
        assert (state === e.st) else begin
            fails++;
            $error("FAIL %s state: observed %0d expected %0d", e.tag, state, e.st);
        end
        vectors++;
        assert (obs === e.outs) else begin
            fails++;
            $error("FAIL %s outputs: observed %b expected %b", e.tag, obs, e.outs);
        end
        vectors++;
        assert (instr_count === e.cnt) else begin
            fails++;
            $error("FAIL %s instr_count: observed %0d expected %0d", e.tag, instr_count, e.cnt);
        end
    endtask

    // One clock: drive inputs at the falling edge, record expectation, sample 1 time unit later.
    task automatic step(string tag, logic rdy, int st, logic ill = 1'b0, logic in_rst = 1'b0);
        exp_t e;
        @(negedge clk);
        rst       = in_rst;
        mem_ready = rdy;
        e.tag  = tag;
        e.st   = 4'(st);
        e.outs = exp_ctrl(st, opcode, rdy && !in_rst, ill);
        e.cnt  = CW'(ecnt);
        sb.push_back(e);
        #1;
        check();
    endtask

    task automatic bump();
        ecnt = (ecnt + 1) % (1 << CW);
    endtask

    logic [5:0] imm_ops [5] = '{6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010};

    initial begin
        // Reset state, with mem_ready high to confirm FETCH strobes are suppressed.
        step("reset", 1'b1, 0, 1'b0, 1'b1);

        // R-type: 0,1,6,7 then back to FETCH.
        opcode = 6'b000000;
        step("r_fetch", 1, 0); step("r_decode", 1, 1); step("r_exec", 1, 6); step("r_wb", 1, 7);
        bump();

        // lw with memory stalled three cycles in MEMREAD.
        opcode = 6'b100011;
        step("lw_fetch", 1, 0); step("lw_decode", 1, 1); step("lw_adr", 1, 2);
        for (int i = 0; i < 3; i++) step("lw_stall", 0, 3);
        step("lw_read", 1, 3); step("lw_wb", 1, 4);
        bump();

        // sw with memory stalled two cycles: mem_write held three cycles.
        opcode = 6'b101011;
        step("sw_fetch", 1, 0); step("sw_decode", 1, 1); step("sw_adr", 1, 2);
        step("sw_stall", 0, 5); step("sw_stall", 0, 5); step("sw_write", 1, 5);
        bump();

        // All immediate ops.
        for (int i = 0; i < 5; i++) begin
            opcode = imm_ops[i];
            step("imm_fetch", 1, 0); step("imm_decode", 1, 1);
            step("imm_exec", 1, 9); step("imm_wb", 1, 10);
            bump();
        end

        // Illegal opcode: straight back to FETCH, one-cycle pulse, no retire.
        opcode = 6'b111111;
        step("ill_fetch", 1, 0); step("ill_decode", 1, 1);
        step("ill_pulse", 0, 0, 1'b1); step("ill_clear", 0, 0);

        // Branches.
        opcode = 6'b000101;
        step("bne_fetch", 1, 0); step("bne_decode", 1, 1); step("bne_br", 1, 8);
        bump();
        opcode = 6'b000100;
        step("beq_fetch", 1, 0); step("beq_decode", 1, 1); step("beq_br", 1, 8);
        bump();

        // Jump.
        opcode = 6'b000010;
        step("j_fetch", 1, 0); step("j_decode", 1, 1); step("j_jump", 1, 11);
        bump();

        // FETCH holds without mem_ready.
        step("fetch_hold", 0, 0); step("fetch_hold", 0, 0);

        // Reset asserted mid-EXECUTE abandons the instruction and clears the count.
        opcode = 6'b000000;
        step("rr_fetch", 1, 0); step("rr_decode", 1, 1); step("rr_exec", 1, 6);
        ecnt = 0;
        step("rst_mid", 1, 0, 1'b0, 1'b1); step("rst_hold", 1, 0, 1'b0, 1'b1);
        step("post_rst", 0, 0);

        // Counter wrap: enough jumps to pass 2^CW.
        opcode = 6'b000010;
        for (int i = 0; i < (1 << CW) + 1; i++) begin
            step("wrap_fetch", 1, 0); step("wrap_decode", 1, 1); step("wrap_jump", 1, 11);
            bump();
        end
        step("wrap_end", 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
